// File: rtl/position_update_sequencer.sv
// Address sequencer for the double-buffered position memory: clears the destination bank,
// streams the source bank to the update pipeline, drains, then reports done to the phase controller.
module position_update_sequencer #(
  parameter int DBSIZE   = 256,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 3,
  parameter int CLEAR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic              double_buffer,
  input  logic              rd_ready,
  input  logic              clr_stall,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we,
  output logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done
);

  localparam int OFF_W      = $clog2(DBSIZE);
  localparam int CNT_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int DRAIN_INIT = (RD_LAT > 0) ? RD_LAT - 1 : 0;

  localparam logic [OFF_W-1:0]  OFF_LAST   = OFF_W'(DBSIZE - 1);
  localparam logic [ADDR_W-1:0] BANK_SIZE  = ADDR_W'(DBSIZE);
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_INIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [OFF_W-1:0]  off, off_nxt, off_inc;
  logic [CNT_W-1:0]  drain_cnt, drain_cnt_nxt;
  logic              bank, bank_nxt;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] rd_addr_nxt, clr_addr_nxt, dst_base_nxt;
  logic              rd_valid_nxt, clr_we_nxt, busy_nxt, done_nxt;
  logic              clr_fire, rd_fire, off_last;

  assign src_base = bank ? BANK_SIZE : '0;
  assign off_inc  = off + 1'b1;
  assign off_last = (off == OFF_LAST);
  // A clear write counts only if the memory port was free while clr_we was presented.
  assign clr_fire = clr_we & ~clr_stall;
  assign rd_fire  = rd_valid & rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!ready) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_nxt = (CLEAR_EN != 0) ? S_CLEAR : S_STREAM;
        S_CLEAR:  if (clr_fire && off_last) state_nxt = S_STREAM;
        S_STREAM: if (rd_fire && off_last) state_nxt = (RD_LAT == 0) ? S_DONE : S_DRAIN;
        S_DRAIN:  if (drain_cnt == '0) state_nxt = S_DONE;
        default:  state_nxt = state;
      endcase
    end
  end

  // Next values of every registered output; strobes default low so an abort clears them.
  always_comb begin
    off_nxt       = off;
    drain_cnt_nxt = drain_cnt;
    bank_nxt      = bank;
    dst_base_nxt  = dst_base;
    rd_addr_nxt   = rd_addr;
    clr_addr_nxt  = clr_addr;
    rd_valid_nxt  = 1'b0;
    clr_we_nxt    = 1'b0;
    busy_nxt      = (state_nxt == S_CLEAR) || (state_nxt == S_STREAM) || (state_nxt == S_DRAIN);
    done_nxt      = (state_nxt == S_DONE);
    if (ready) begin
      case (state)
        S_IDLE: begin
          bank_nxt     = double_buffer;
          dst_base_nxt = double_buffer ? '0 : BANK_SIZE;
          off_nxt      = '0;
        end
        S_CLEAR: begin
          if (clr_stall) begin
            clr_we_nxt = 1'b0;
          end else if (clr_we) begin
            if (off_last) begin
              off_nxt      = '0;
              rd_valid_nxt = 1'b1;
              rd_addr_nxt  = src_base;
            end else begin
              off_nxt      = off_inc;
              clr_we_nxt   = 1'b1;
              clr_addr_nxt = dst_base + ADDR_W'(off_inc);
            end
          end else begin
            // Entry or post-stall bubble: (re)issue the current offset.
            clr_we_nxt   = 1'b1;
            clr_addr_nxt = dst_base + ADDR_W'(off);
          end
        end
        S_STREAM: begin
          if (rd_fire) begin
            if (off_last) begin
              drain_cnt_nxt = DRAIN_LOAD;
            end else begin
              off_nxt      = off_inc;
              rd_valid_nxt = 1'b1;
              rd_addr_nxt  = src_base + ADDR_W'(off_inc);
            end
          end else begin
            rd_valid_nxt = 1'b1;
            rd_addr_nxt  = src_base + ADDR_W'(off);
          end
        end
        S_DRAIN: begin
          if (drain_cnt != '0) drain_cnt_nxt = drain_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off       <= '0;
      drain_cnt <= '0;
      bank      <= 1'b0;
      dst_base  <= '0;
      rd_addr   <= '0;
      clr_addr  <= '0;
      rd_valid  <= 1'b0;
      clr_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      off       <= off_nxt;
      drain_cnt <= drain_cnt_nxt;
      bank      <= bank_nxt;
      dst_base  <= dst_base_nxt;
      rd_addr   <= rd_addr_nxt;
      clr_addr  <= clr_addr_nxt;
      rd_valid  <= rd_valid_nxt;
      clr_we    <= clr_we_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_position_update_sequencer.sv
// Scoreboard bench: two sequencer configurations share the phase inputs; a negedge monitor
// checks every clear write and read accept against per-pass address lists built at pass start.
`timescale 1ns/1ps
module tb_position_update_sequencer;

  localparam int DB = 4;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1, rst_b = 1'b1;
  logic ready = 1'b0, double_buffer = 1'b0, rd_ready = 1'b1, clr_stall = 1'b0;

  logic [AW-1:0] rd_addr_a, clr_addr_a, dst_base_a;
  logic          rd_valid_a, clr_we_a, busy_a, done_a;
  logic [AW-1:0] rd_addr_b, clr_addr_b, dst_base_b;
  logic          rd_valid_b, clr_we_b, busy_b, done_b;

  always #5 clk = ~clk;

  position_update_sequencer #(.DBSIZE(DB), .ADDR_W(AW), .RD_LAT(2), .CLEAR_EN(1)) dut_a (
    .clk(clk), .rst(rst), .ready(ready), .double_buffer(double_buffer),
    .rd_ready(rd_ready), .clr_stall(clr_stall),
    .rd_addr(rd_addr_a), .rd_valid(rd_valid_a), .clr_addr(clr_addr_a), .clr_we(clr_we_a),
    .dst_base(dst_base_a), .busy(busy_a), .done(done_a)
  );

  position_update_sequencer #(.DBSIZE(DB), .ADDR_W(AW), .RD_LAT(0), .CLEAR_EN(0)) dut_b (
    .clk(clk), .rst(rst_b), .ready(ready), .double_buffer(double_buffer),
    .rd_ready(rd_ready), .clr_stall(clr_stall),
    .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .clr_addr(clr_addr_b), .clr_we(clr_we_b),
    .dst_base(dst_base_b), .busy(busy_b), .done(done_b)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int clr_q_a[$], rd_q_a[$], rd_q_b[$];
  int start_cyc, done_a_cyc, done_b_cyc, last_acc_b_cyc;
  bit rand_mode = 0;
  int rd_stall_addr = -1, rd_stall_left = 0;
  int clr_pulse_addr = -1;
  bit clr_pulse_done = 1;

  logic          prev_clr_hold = 0, prev_rd_hold = 0, done_a_prev = 0, done_b_prev = 0;
  logic [AW-1:0] prev_clr_addr = '0, prev_rd_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs and outputs are stable at negedge for the coming active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_clr_hold = 0;
      prev_rd_hold  = 0;
      done_a_prev   = 0;
    end else begin
      if (prev_clr_hold) begin
        chk("clr_stall_we", clr_we_a, 0);
        chk("clr_stall_addr", clr_addr_a, prev_clr_addr);
      end
      if (prev_rd_hold) begin
        chk("rd_stall_valid", rd_valid_a, 1);
        chk("rd_stall_addr", rd_addr_a, prev_rd_addr);
      end
      if (clr_we_a || rd_valid_a) chk("strobe_excl", clr_we_a && rd_valid_a, 0);
      if (ready && clr_we_a && !clr_stall) begin
        if (clr_q_a.size() == 0) chk("clr_extra", clr_addr_a, 32'hFFFF_FFFF);
        else chk("clr_addr", clr_addr_a, clr_q_a.pop_front());
      end
      if (ready && rd_valid_a && rd_ready) begin
        if (rd_q_a.size() == 0) chk("rd_extra_a", rd_addr_a, 32'hFFFF_FFFF);
        else chk("rd_addr_a", rd_addr_a, rd_q_a.pop_front());
      end
      if (done_a && !done_a_prev) done_a_cyc = cyc;
      prev_clr_hold = ready && clr_we_a && clr_stall;
      prev_clr_addr = clr_addr_a;
      prev_rd_hold  = ready && rd_valid_a && !rd_ready;
      prev_rd_addr  = rd_addr_a;
      done_a_prev   = done_a;
    end
    if (rst_b) begin
      done_b_prev = 0;
    end else begin
      if (busy_b) chk("clr_we_b", clr_we_b, 0);
      if (ready && rd_valid_b && rd_ready) begin
        if (rd_q_b.size() == 0) chk("rd_extra_b", rd_addr_b, 32'hFFFF_FFFF);
        else chk("rd_addr_b", rd_addr_b, rd_q_b.pop_front());
        last_acc_b_cyc = cyc + 1;
      end
      if (done_b && !done_b_prev) done_b_cyc = cyc;
      done_b_prev = done_b;
    end
  end

  task automatic start_pass(input logic db, input bit rand_on);
    @(posedge clk); #1;
    clr_q_a.delete(); rd_q_a.delete(); rd_q_b.delete();
    for (int i = 0; i < DB; i++) begin
      clr_q_a.push_back((db ? 0 : DB) + i);
      rd_q_a.push_back((db ? DB : 0) + i);
      rd_q_b.push_back((db ? DB : 0) + i);
    end
    double_buffer  = db;
    ready          = 1'b1;
    start_cyc      = cyc + 1;
    done_a_cyc     = -1;
    done_b_cyc     = -1;
    last_acc_b_cyc = -2;
    rand_mode      = rand_on;
    @(posedge clk); #1;
    chk("dst_base_a", dst_base_a, db ? 0 : DB);
    chk("dst_base_b", dst_base_b, db ? 0 : DB);
    chk("busy_start", busy_a, 1);
  endtask

  task automatic run_until_done(input int budget, output int lat);
    int n = 0;
    while (!(done_a && done_b) && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (rand_mode) begin
        rd_ready      = ($urandom_range(0, 3) != 0);
        clr_stall     = ($urandom_range(0, 4) == 0);
        double_buffer = $urandom_range(0, 1);
      end else begin
        rd_ready      = 1'b1;
        clr_stall     = 1'b0;
        double_buffer = ~double_buffer;
        if (rd_stall_left > 0 && rd_valid_a && rd_addr_a == rd_stall_addr) begin
          rd_ready = 1'b0;
          rd_stall_left--;
        end
        if (!clr_pulse_done && clr_we_a && clr_addr_a == clr_pulse_addr) begin
          clr_stall      = 1'b1;
          clr_pulse_done = 1;
        end
      end
    end
    @(negedge clk); #1;
    rd_ready  = 1'b1;
    clr_stall = 1'b0;
    rand_mode = 0;
    chk("pass_done", done_a && done_b, 1);
    chk("clr_left", clr_q_a.size(), 0);
    chk("rd_left_a", rd_q_a.size(), 0);
    chk("rd_left_b", rd_q_b.size(), 0);
    chk("done_b_after_acc", done_b_cyc, last_acc_b_cyc);
    lat = done_a_cyc - start_cyc;
  endtask

  task automatic end_pass();
    @(posedge clk); #1;
    ready = 1'b0;
    @(posedge clk); #1;
    chk("done_drop_a", done_a, 0);
    chk("done_drop_b", done_b, 0);
    chk("busy_drop", busy_a, 0);
  endtask

  initial begin
    int lat;
    int n;
    #2;
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_rd_valid", rd_valid_a, 0);
    chk("rst_clr_addr", clr_addr_a, 0);
    chk("rst_clr_we", clr_we_a, 0);
    chk("rst_dst_base", dst_base_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rst_b = 1'b0;

    // Plain pass, bank 0, then bank 1 with double_buffer toggling mid-pass.
    start_pass(1'b0, 0);
    run_until_done(60, lat);
    chk("t1_latency", lat, 11);
    end_pass();
    start_pass(1'b1, 0);
    run_until_done(60, lat);
    chk("t2_latency", lat, 11);
    end_pass();

    // Read back-pressure for three cycles on address 2.
    rd_stall_addr = 2;
    rd_stall_left = 3;
    start_pass(1'b0, 0);
    run_until_done(60, lat);
    chk("t3_latency", lat, 14);
    end_pass();

    // Single clear stall while address 5 is being written.
    clr_pulse_addr = 5;
    clr_pulse_done = 0;
    start_pass(1'b0, 0);
    run_until_done(60, lat);
    end_pass();

    // Abort at read address 1, then restart on bank 1.
    start_pass(1'b0, 0);
    n = 0;
    while (!(rd_valid_a && rd_addr_a == 1) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reach", rd_valid_a && rd_addr_a == 1, 1);
    ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_rd_valid", rd_valid_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    start_pass(1'b1, 0);
    run_until_done(60, lat);
    chk("t5_latency", lat, 11);
    end_pass();

    // Asynchronous reset of the no-clear instance mid-stream.
    start_pass(1'b0, 0);
    @(posedge clk); #1;
    chk("t6_streaming", rd_valid_b, 1);
    #3;
    rst_b = 1'b1;
    #1;
    chk("arst_rd_valid", rd_valid_b, 0);
    chk("arst_rd_addr", rd_addr_b, 0);
    chk("arst_dst_base", dst_base_b, 0);
    chk("arst_busy", busy_b, 0);
    chk("arst_done", done_b, 0);
    chk("arst_clr_we", clr_we_b, 0);
    chk("arst_clr_addr", clr_addr_b, 0);
    @(posedge clk); #1;
    ready = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("t6_abort_busy", busy_a, 0);

    // Randomized passes: random back-pressure, clear stalls and bank-select noise.
    for (int k = 0; k < 10; k++) begin
      start_pass(1'($urandom_range(0, 1)), 1);
      run_until_done(400, lat);
      chk("rand_lat_min", lat >= 11, 1);
      end_pass();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
    $fatal(1, "watchdog");
  end

endmodule
